// File: rtl/clahe_lut_div_sequencer.sv
// CDF->LUT divide sequencer: streams one divide per bin into a fixed-latency
// divider, then saturates the in-order quotients into the tile LUT.
module clahe_lut_div_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int CDF_WIDTH   = 17,
    parameter int BINS        = 256,
    parameter int BIN_AW      = 8,
    parameter int DIV_LATENCY = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CDF_WIDTH-1:0]  cdf_min,
    input  logic [CDF_WIDTH-1:0]  total_pixels,
    output logic                  cdf_rd_en,
    output logic [BIN_AW-1:0]     cdf_rd_addr,
    input  logic [CDF_WIDTH-1:0]  cdf_rd_data,
    output logic                  div_start,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    input  logic                  div_done,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    output logic                  lut_wr_en,
    output logic [BIN_AW-1:0]     lut_wr_addr,
    output logic [7:0]            lut_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_unexp
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;
    localparam int OUT_W = $clog2(DIV_LATENCY + 2) + 1;

    logic [1:0]            state_q, state_d;
    logic [BIN_AW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [BIN_AW:0]       wr_cnt_q, wr_cnt_d;
    logic [CDF_WIDTH-1:0]  cmin_q, cmin_d;
    logic [CDF_WIDTH-1:0]  den_q, den_d;
    logic                  ident_q, ident_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [BIN_AW-1:0]     rd_idx_q, rd_idx_d;
    logic                  div_start_q, div_start_d;
    logic [DATA_WIDTH-1:0] div_dividend_q, div_dividend_d;
    logic [DATA_WIDTH-1:0] div_divisor_q, div_divisor_d;
    logic                  lut_wr_en_q, lut_wr_en_d;
    logic [BIN_AW-1:0]     lut_wr_addr_q, lut_wr_addr_d;
    logic [7:0]            lut_wr_data_q, lut_wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [OUT_W-1:0]      outst_q, outst_d;
    logic [CDF_WIDTH-1:0]  num;
    logic                  accept;

    function automatic logic [7:0] sat8(input logic [DATA_WIDTH-1:0] q);
        return (q > DATA_WIDTH'(255)) ? 8'hFF : q[7:0];
    endfunction

    // x*255 computed as (x<<8)-x on the zero-extended operand
    function automatic logic [DATA_WIDTH-1:0] scale255(input logic [CDF_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] ext;
        ext = DATA_WIDTH'(x);
        return (ext << 8) - ext;
    endfunction

    always_comb begin
        state_d        = state_q;
        rd_cnt_d       = rd_cnt_q;
        wr_cnt_d       = wr_cnt_q;
        cmin_d         = cmin_q;
        den_d          = den_q;
        ident_d        = ident_q;
        done_d         = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_ISSUE;
                cmin_d   = cdf_min;
                den_d    = total_pixels - cdf_min;
                ident_d  = (total_pixels <= cdf_min);
                rd_cnt_d = '0;
                wr_cnt_d = '0;
            end
            S_ISSUE: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == BIN_AW'(BINS - 1)) state_d = S_DRAIN;
            end
            S_DRAIN: if (wr_cnt_q == (BIN_AW + 1)'(BINS)) begin
                state_d = S_FIN;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Issue stage: operands formed from the CDF word read last cycle
        rd_vld_d       = (state_q == S_ISSUE);
        rd_idx_d       = rd_cnt_q;
        num            = (cdf_rd_data < cmin_q) ? '0 : cdf_rd_data - cmin_q;
        div_start_d    = rd_vld_q;
        div_dividend_d = '0;
        div_divisor_d  = '0;
        if (rd_vld_q) begin
            if (ident_q) begin
                div_dividend_d = DATA_WIDTH'(rd_idx_q);
                div_divisor_d  = DATA_WIDTH'(1);
            end else begin
                div_dividend_d = scale255(num);
                div_divisor_d  = DATA_WIDTH'(den_q);
            end
        end

        // Collect stage: quotients only count against an outstanding request
        accept        = div_done && (outst_q != '0) && (state_q != S_IDLE);
        lut_wr_en_d   = accept;
        lut_wr_addr_d = accept ? wr_cnt_q[BIN_AW-1:0] : '0;
        lut_wr_data_d = accept ? sat8(div_quotient) : 8'h00;
        if (accept) wr_cnt_d = wr_cnt_q + 1'b1;
        err_d = err_q | (div_done && (outst_q == '0) && (state_q != S_IDLE));

        outst_d = outst_q;
        case ({div_start_q, div_done && (outst_q != '0)})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            cmin_q         <= '0;
            den_q          <= '0;
            ident_q        <= 1'b0;
            rd_vld_q       <= 1'b0;
            rd_idx_q       <= '0;
            div_start_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            lut_wr_en_q    <= 1'b0;
            lut_wr_addr_q  <= '0;
            lut_wr_data_q  <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            outst_q        <= '0;
        end else begin
            state_q        <= state_d;
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            cmin_q         <= cmin_d;
            den_q          <= den_d;
            ident_q        <= ident_d;
            rd_vld_q       <= rd_vld_d;
            rd_idx_q       <= rd_idx_d;
            div_start_q    <= div_start_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            lut_wr_en_q    <= lut_wr_en_d;
            lut_wr_addr_q  <= lut_wr_addr_d;
            lut_wr_data_q  <= lut_wr_data_d;
            done_q         <= done_d;
            err_q          <= err_d;
            outst_q        <= outst_d;
        end
    end

    assign cdf_rd_en    = (state_q == S_ISSUE);
    assign cdf_rd_addr  = (state_q == S_ISSUE) ? rd_cnt_q : '0;
    assign busy         = (state_q != S_IDLE);
    assign div_start    = div_start_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;
    assign lut_wr_en    = lut_wr_en_q;
    assign lut_wr_addr  = lut_wr_addr_q;
    assign lut_wr_data  = lut_wr_data_q;
    assign done         = done_q;
    assign err_unexp    = err_q;

endmodule

// File: tb/tb_clahe_lut_div_sequencer.sv
// Bench for clahe_lut_div_sequencer: CDF RAM and fixed-latency divider models,
// table-driven jobs checked against the LUT mapping formula.
module tb_clahe_lut_div_sequencer;

    localparam int LAT  = 33;
    localparam int BINS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [16:0] cdf_min = '0;
    logic [16:0] total_pixels = '0;
    logic        cdf_rd_en;
    logic [7:0]  cdf_rd_addr;
    logic [16:0] cdf_rd_data;
    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_done;
    logic [31:0] div_quotient;
    logic        lut_wr_en;
    logic [7:0]  lut_wr_addr;
    logic [7:0]  lut_wr_data;
    logic        busy;
    logic        done;
    logic        err_unexp;
    logic        inj = 1'b0;

    int total = 0;
    int bad = 0;

    logic [16:0] mem [BINS];
    logic [LAT-1:0] vsr;
    logic [31:0] qsr [LAT];

    clahe_lut_div_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cdf_min(cdf_min),
        .total_pixels(total_pixels), .cdf_rd_en(cdf_rd_en), .cdf_rd_addr(cdf_rd_addr),
        .cdf_rd_data(cdf_rd_data), .div_start(div_start), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_done(div_done), .div_quotient(div_quotient),
        .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
        .busy(busy), .done(done), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    // CDF RAM: data valid the cycle after the read enable
    always @(posedge clk) if (cdf_rd_en) cdf_rd_data <= mem[cdf_rd_addr];

    // Divider: fixed latency, no reset, so stale results survive a DUT reset
    always @(posedge clk) begin
        vsr <= {vsr[LAT-2:0], div_start};
        qsr[0] <= (div_divisor == 0) ? 32'd0 : div_dividend / div_divisor;
        for (int k = 1; k < LAT; k++) qsr[k] <= qsr[k-1];
    end
    assign div_done     = vsr[LAT-1] | inj;
    assign div_quotient = inj ? 32'd1234 : qsr[LAT-1];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint num_of(input int k, input int cmin);
        return (int'(mem[k]) < cmin) ? 0 : longint'(mem[k]) - cmin;
    endfunction

    function automatic longint ref_lut(input int k, input int cmin, input int tot);
        longint q;
        if (tot <= cmin) return k;
        q = num_of(k, cmin) * 255 / (tot - cmin);
        return (q > 255) ? 255 : q;
    endfunction

    function automatic longint ref_dvd(input int k, input int cmin, input int tot);
        return (tot <= cmin) ? k : num_of(k, cmin) * 255;
    endfunction

    function automatic longint ref_dvs(input int cmin, input int tot);
        return (tot <= cmin) ? 1 : tot - cmin;
    endfunction

    task automatic fill_mem(input int mode, input int tot);
        for (int i = 0; i < BINS; i++) begin
            case (mode)
                0: mem[i] = 17'(i + 1);
                1: mem[i] = 17'd4096;
                2: mem[i] = 17'($urandom_range(10, 200));
                default: mem[i] = 17'($urandom_range(0, tot + 2000));
            endcase
        end
        if (mode == 2) begin
            mem[0] = 17'd0;
            mem[5] = 17'd300;
        end
    endtask

    // Runs one job from an IDLE negedge; returns at the negedge after FIN
    task automatic run_job(input int cmin, input int tot, input int s2,
                           input int inj_at, input int exp_err);
        int e, done_e, first_ds, nds, nwr, opbad;
        int got [BINS];
        for (int i = 0; i < BINS; i++) got[i] = -1;
        cdf_min = 17'(cmin);
        total_pixels = 17'(tot);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 0; done_e = -1; first_ds = -1; nds = 0; nwr = 0; opbad = 0;
        while (done_e < 0 && e < 600) begin
            if (lut_wr_en) begin
                nwr++;
                got[lut_wr_addr] = int'(lut_wr_data);
            end
            if (div_start) begin
                if (first_ds < 0) first_ds = e;
                if (nds < BINS && (longint'(div_divisor) != ref_dvs(cmin, tot) ||
                    longint'(div_dividend) != ref_dvd(nds, cmin, tot))) opbad++;
                nds++;
            end
            if (done) done_e = e;
            if (e == s2 - 1) start = 1'b1;
            if (e == s2) begin
                start = 1'b0;
                chk("busy_at_second_start", longint'(busy), 1);
            end
            if (e == inj_at) inj = 1'b1;
            if (e == inj_at + 1) inj = 1'b0;
            if (done_e < 0) begin
                @(posedge clk);
                @(negedge clk);
                e++;
            end
        end
        chk("done_edge", done_e, 292);
        chk("first_div_start_edge", first_ds, 2);
        chk("div_start_count", nds, BINS);
        chk("lut_write_count", nwr, BINS);
        chk("operand_errors", opbad, 0);
        chk("err_unexp_after_job", longint'(err_unexp), exp_err);
        for (int i = 0; i < BINS; i++) chk($sformatf("lut[%0d]", i), got[i], ref_lut(i, cmin, tot));
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_job", longint'(busy), 0);
    endtask

    typedef struct {
        int mode;
        int cmin;
        int tot;
        int s2;
        int exp_done;
    } vec_t;

    vec_t vt [6];

    initial begin
        int cnt;
        vt[0] = '{0, 1, 256, -1, 292};
        vt[1] = '{1, 4096, 4096, -1, 292};
        vt[2] = '{2, 10, 200, -1, 292};
        vt[3] = '{3, 0, 0, 50, 292};
        vt[4] = '{3, 0, 0, -1, 292};
        vt[5] = '{3, 5000, 3000, -1, 292};
        for (int i = 3; i < 5; i++) begin
            vt[i].cmin = int'($urandom_range(0, 1000));
            vt[i].tot  = vt[i].cmin + int'($urandom_range(1, 60000));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", longint'({cdf_rd_en, div_start, lut_wr_en, busy, done, err_unexp}), 0);
        chk("reset_operands", longint'(div_dividend | div_divisor), 0);

        // Back-to-back jobs: each starts at the first IDLE cycle after the previous
        for (int v = 0; v < 6; v++) begin
            fill_mem(vt[v].mode, vt[v].tot);
            run_job(vt[v].cmin, vt[v].tot, vt[v].s2, -1, 0);
        end

        // Reset in the middle of ISSUE, with divider results still in flight
        fill_mem(3, 40000);
        cdf_min = 17'd100;
        total_pixels = 17'd40000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            if (e == 100) rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        chk("midjob_reset_outputs",
            longint'({cdf_rd_en, div_start, lut_wr_en, busy, done, err_unexp}), 0);
        chk("midjob_reset_operands", longint'(div_dividend | div_divisor | 32'(lut_wr_data)), 0);
        cnt = 0;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (lut_wr_en) cnt++;
        end
        chk("stale_done_writes", cnt, 0);
        chk("stale_done_err", longint'(err_unexp), 0);
        run_job(100, 40000, -1, -1, 0);

        // Unexpected div_done before any request has been issued
        fill_mem(3, 20000);
        run_job(300, 20000, -1, 1, 1);
        repeat (5) @(negedge clk);
        chk("err_sticky", longint'(err_unexp), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("err_cleared_by_rst", longint'(err_unexp), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
